karatsuba_overlap_pipe: RTL and testbench

- Parametrised, pipelined recombination stage for GF(2) Karatsuba multipliers of any even operand width N.
- Takes the three half-width partial products (low, middle, high), optionally corrects the middle term, and overlap-XORs the three into one 2N-1 bit carry-less product.
- Has a two-stage valid/ready pipeline with full backpressure and a product counter.
- Sits after the three sub-multipliers of one Karatsuba level; can be stacked recursively.

---
 rtl/karatsuba_overlap_pipe.sv | 123 ++++++++++++
 tb/tb_karatsuba_overlap_pipe.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_overlap_pipe.sv
// rtl/karatsuba_overlap_pipe.sv - Karatsuba GF(2) recombination stage with 2-deep valid/ready pipeline
//
// Purpose:
//   Takes the three half-width carry-less partial products of one Karatsuba
//   level (lo = a0*b0, mid, hi = a1*b1). It optionally corrects the middle
//   term, then overlap-XORs them into a single 2N-1 bit carry-less product:
//     prod = lo ^ (mid_c << N/2) ^ (hi << N)
//   Stage 1 registers lo / corrected mid / hi. Stage 2 registers the
//   overlapped product. Both stages use full valid/ready backpressure, and
//   the stage sustains one product per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   partial-product set presented
//   in_ready   stage can accept the set this cycle (combinational from out_ready)
//   in_mode    0: in_mid already corrected, 1: in_mid is raw (a0^a1)(b0^b1)
//   in_lo      low product  a0*b0           (N-1 bits)
//   in_mid     middle product               (N-1 bits)
//   in_hi      high product a1*b1           (N-1 bits)
//   out_valid  product valid
//   out_ready  downstream accepts
//   out_prod   carry-less product           (2N-1 bits)
//   prod_count number of products accepted downstream (wraps)
//
// N must be even and >= 4.

module karatsuba_overlap_pipe #(
  parameter int N     = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [N-2:0]     in_lo,
  input  logic [N-2:0]     in_mid,
  input  logic [N-2:0]     in_hi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-2:0]   out_prod,
  output logic [CNT_W-1:0] prod_count
);

  localparam int H  = N / 2;
  localparam int OW = 2 * N - 1;

  logic             r_s1_valid;
  logic [N-2:0]     r_s1_lo;
  logic [N-2:0]     r_s1_mid;
  logic [N-2:0]     r_s1_hi;
  logic             r_out_valid;
  logic [OW-1:0]    r_out_prod;
  logic [CNT_W-1:0] r_count;

  logic             w_in_fire;
  logic             w_s2_load;
  logic             w_out_fire;
  logic [N-2:0]     w_mid_c;
  logic [OW-1:0]    w_overlap;

  // Stage 2 refills whenever its slot is empty or being drained this cycle.
  // Stage 1 may therefore accept a new set in the same cycle it hands off,
  // which is what gives one product per cycle without a skid buffer.
  assign w_s2_load  = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready   = !r_s1_valid || w_s2_load;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // A raw middle product still contains a0*b0 ^ a1*b1. Removing both leaves
  // the cross terms a0*b1 ^ a1*b0.
  assign w_mid_c = in_mode ? (in_mid ^ in_lo ^ in_hi) : in_mid;

  // Zero-extend each N-1 bit term to 2N-1 bits before shifting. Bits that a
  // term does not cover then contribute 0 to the XOR.
  always_comb begin
    w_overlap = {{N{1'b0}}, r_s1_lo};
    w_overlap = w_overlap ^ ({{N{1'b0}}, r_s1_mid} << H);
    w_overlap = w_overlap ^ ({{N{1'b0}}, r_s1_hi} << N);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_lo    <= '0;
      r_s1_mid   <= '0;
      r_s1_hi    <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_lo    <= in_lo;
      r_s1_mid   <= w_mid_c;
      r_s1_hi    <= in_hi;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_prod  <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= 1'b1;
      r_out_prod  <= w_overlap;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_out_fire) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_prod   = r_out_prod;
  assign prod_count = r_count;

endmodule

// File: tb/tb_karatsuba_overlap_pipe.sv
// tb/tb_karatsuba_overlap_pipe.sv - self-checking bench for karatsuba_overlap_pipe (N=8/CNT_W=4 and N=64/CNT_W=16)

module tb_karatsuba_overlap_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // N=8, CNT_W=4 instance
  logic        d8_in_valid, d8_in_ready, d8_in_mode, d8_out_valid, d8_out_ready;
  logic [6:0]  d8_lo, d8_mid, d8_hi;
  logic [14:0] d8_prod;
  logic [3:0]  d8_cnt;

  // N=64, CNT_W=16 instance
  logic         d64_in_valid, d64_in_ready, d64_in_mode, d64_out_valid, d64_out_ready;
  logic [62:0]  d64_lo, d64_mid, d64_hi;
  logic [126:0] d64_prod;
  logic [15:0]  d64_cnt;

  karatsuba_overlap_pipe #(.N(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(d8_in_valid), .in_ready(d8_in_ready), .in_mode(d8_in_mode),
    .in_lo(d8_lo), .in_mid(d8_mid), .in_hi(d8_hi),
    .out_valid(d8_out_valid), .out_ready(d8_out_ready),
    .out_prod(d8_prod), .prod_count(d8_cnt)
  );

  karatsuba_overlap_pipe #(.N(64), .CNT_W(16)) u_dut64 (
    .clk(clk), .rst(rst),
    .in_valid(d64_in_valid), .in_ready(d64_in_ready), .in_mode(d64_in_mode),
    .in_lo(d64_lo), .in_mid(d64_mid), .in_hi(d64_hi),
    .out_valid(d64_out_valid), .out_ready(d64_out_ready),
    .out_prod(d64_prod), .prod_count(d64_cnt)
  );

  // Reference carry-less multiply, shift-and-XOR over the bits of b.
  function automatic logic [127:0] clmul(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (b[i]) r = r ^ ({64'b0, a} << i);
    return r;
  endfunction

  // Split n-bit operands into halves and form the Karatsuba partial products.
  // The expected result is the full clmul of the n-bit operands.
  task automatic make_set(input int n, input logic [63:0] a_in, input logic [63:0] b_in,
                          input bit mode, output logic [63:0] lo, output logic [63:0] mid,
                          output logic [63:0] hi, output logic [127:0] ex);
    logic [63:0] nmask, hmask, a, b, a0, a1, b0, b1;
    int h;
    h     = n / 2;
    nmask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    hmask = (64'd1 << h) - 64'd1;
    a  = a_in & nmask;
    b  = b_in & nmask;
    a0 = a & hmask;
    a1 = (a >> h) & hmask;
    b0 = b & hmask;
    b1 = (b >> h) & hmask;
    lo  = clmul(a0, b0)[63:0];
    hi  = clmul(a1, b1)[63:0];
    mid = clmul(a0 ^ a1, b0 ^ b1)[63:0];
    if (!mode) mid = mid ^ lo ^ hi;
    ex = clmul(a, b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d8_in_valid = 0; d8_in_mode = 0; d8_lo = '0; d8_mid = '0; d8_hi = '0; d8_out_ready = 0;
    d64_in_valid = 0; d64_in_mode = 0; d64_lo = '0; d64_mid = '0; d64_hi = '0; d64_out_ready = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (d8_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid8: got %b want 0", d8_out_valid); end
    n_cmp++; if (d8_prod !== 15'h0) begin n_fail++; $display("FAIL reset_prod8: got %h want 0", d8_prod); end
    n_cmp++; if (d8_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_cnt8: got %0d want 0", d8_cnt); end
    n_cmp++; if (d64_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid64: got %b want 0", d64_out_valid); end
    n_cmp++; if (d64_prod !== 127'h0) begin n_fail++; $display("FAIL reset_prod64: got %h want 0", d64_prod); end
    n_cmp++; if (d64_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt64: got %0d want 0", d64_cnt); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (d8_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready8: got %b want 1", d8_in_ready); end
    n_cmp++; if (d64_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready64: got %b want 1", d64_in_ready); end
  endtask

  task automatic test_directed_n8();
    bit          t_mode[3] = '{1'b1, 1'b0, 1'b1};
    logic [6:0]  t_lo[3]   = '{7'h05, 7'h7F, 7'h00};
    logic [6:0]  t_mid[3]  = '{7'h05, 7'h7F, 7'h01};
    logic [6:0]  t_hi[3]   = '{7'h00, 7'h7F, 7'h01};
    logic [14:0] t_exp[3]  = '{15'h0005, 15'h788F, 15'h0100};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      d8_in_valid = 1; d8_in_mode = t_mode[k]; d8_lo = t_lo[k]; d8_mid = t_mid[k]; d8_hi = t_hi[k];
      d8_out_ready = 1;
      #1;
      n_cmp++; if (d8_in_ready !== 1'b1) begin n_fail++; $display("FAIL dir_in_ready[%0d]: got %b want 1", k, d8_in_ready); end
      @(negedge clk);
      d8_in_valid = 0;
      n_cmp++; if (d8_out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_early_valid[%0d]: got %b want 0", k, d8_out_valid); end
      @(negedge clk);
      n_cmp++; if (d8_out_valid !== 1'b1) begin n_fail++; $display("FAIL dir_out_valid[%0d]: got %b want 1", k, d8_out_valid); end
      n_cmp++; if (d8_prod !== t_exp[k]) begin n_fail++; $display("FAIL dir_prod[%0d]: got %h want %h", k, d8_prod, t_exp[k]); end
      @(negedge clk);
      n_cmp++; if (d8_cnt !== 4'(k + 1)) begin n_fail++; $display("FAIL dir_cnt[%0d]: got %0d want %0d", k, d8_cnt, k + 1); end
      n_cmp++; if (d8_out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_drain[%0d]: got %b want 0", k, d8_out_valid); end
    end
  endtask

  task automatic test_back_to_back_n64();
    logic [126:0] q[$];
    logic [126:0] ex_cur, got_exp;
    logic [63:0]  lo, mid, hi;
    logic [127:0] ex;
    bit pending = 0;
    int sent = 0, recv = 0, cyc = 0;
    while (recv < 100 && cyc < 300) begin
      @(negedge clk);
      d64_out_ready = 1;
      if (sent < 100) begin
        if (!pending) begin
          d64_in_mode = 1'($urandom_range(0, 1));
          make_set(64, {$urandom, $urandom}, {$urandom, $urandom}, d64_in_mode, lo, mid, hi, ex);
          d64_lo = lo[62:0]; d64_mid = mid[62:0]; d64_hi = hi[62:0];
          ex_cur = ex[126:0];
          pending = 1;
        end
        d64_in_valid = 1;
      end else begin
        d64_in_valid = 0;
      end
      #1;
      if (d64_in_valid && d64_in_ready) begin q.push_back(ex_cur); sent++; pending = 0; end
      if (d64_out_valid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_spurious: got product %h want none", d64_prod);
        end else begin
          got_exp = q.pop_front();
          if (d64_prod !== got_exp) begin n_fail++; $display("FAIL b2b_prod[%0d]: got %h want %h", recv, d64_prod, got_exp); end
        end
        recv++;
      end
      cyc++;
    end
    d64_in_valid = 0;
    n_cmp++; if (recv != 100) begin n_fail++; $display("FAIL b2b_recv: got %0d want 100", recv); end
    n_cmp++; if (cyc != 102) begin n_fail++; $display("FAIL b2b_cycles: got %0d want 102", cyc); end
    @(negedge clk);
    n_cmp++; if (d64_cnt !== 16'd100) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 100", d64_cnt); end
  endtask

  task automatic test_backpressure_n8();
    logic [14:0] q[$];
    logic [14:0] ex_cur, held, got_exp;
    logic [63:0] lo, mid, hi;
    logic [127:0] ex;
    bit pending = 0;
    int sent = 0, recv = 0, cyc = 0;
    held = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!pending) begin
        d8_in_mode = 1'($urandom_range(0, 1));
        make_set(8, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), d8_in_mode, lo, mid, hi, ex);
        d8_lo = lo[6:0]; d8_mid = mid[6:0]; d8_hi = hi[6:0]; ex_cur = ex[14:0];
        pending = 1;
      end
      d8_in_valid = 1; d8_out_ready = 0;
      #1;
      if (c == 2) held = d8_prod;
      if (c >= 3) begin
        n_cmp++; if (d8_prod !== held) begin n_fail++; $display("FAIL bp_stable[%0d]: got %h want %h", c, d8_prod, held); end
        n_cmp++; if (d8_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, d8_in_ready); end
      end
      if (d8_in_valid && d8_in_ready) begin q.push_back(ex_cur); sent++; pending = 0; end
    end
    n_cmp++; if (sent != 2) begin n_fail++; $display("FAIL bp_fill: got %0d accepted want 2", sent); end
    n_cmp++; if (d8_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b want 1", d8_out_valid); end
    n_cmp++; if (q.size() > 0 && held !== q[0]) begin n_fail++; $display("FAIL bp_held: got %h want %h", held, q[0]); end
    while (recv < 8 && cyc < 200) begin
      @(negedge clk);
      d8_out_ready = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      if (sent < 8) begin
        if (!pending) begin
          d8_in_mode = 1'($urandom_range(0, 1));
          make_set(8, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), d8_in_mode, lo, mid, hi, ex);
          d8_lo = lo[6:0]; d8_mid = mid[6:0]; d8_hi = hi[6:0]; ex_cur = ex[14:0];
          pending = 1;
        end
        d8_in_valid = 1;
      end else begin
        d8_in_valid = 0;
      end
      #1;
      if (d8_in_valid && d8_in_ready) begin q.push_back(ex_cur); sent++; pending = 0; end
      if (d8_out_valid && d8_out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL bp_spurious: got product %h want none", d8_prod);
        end else begin
          got_exp = q.pop_front();
          if (d8_prod !== got_exp) begin n_fail++; $display("FAIL bp_prod[%0d]: got %h want %h", recv, d8_prod, got_exp); end
        end
        recv++;
      end
      cyc++;
    end
    d8_in_valid = 0;
    n_cmp++; if (recv != 8 || q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d recv %0d left want 8 recv 0 left", recv, q.size()); end
    @(negedge clk);
    n_cmp++; if (d8_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dup: got out_valid %b want 0", d8_out_valid); end
  endtask

  task automatic test_reset_midop_n8();
    logic [14:0] q[$];
    logic [14:0] ex_cur, got_exp;
    logic [63:0] lo, mid, hi;
    logic [127:0] ex;
    int recv = 0, cyc = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      d8_in_valid = 1; d8_in_mode = 0; d8_out_ready = 0;
      d8_lo = 7'($urandom); d8_mid = 7'($urandom); d8_hi = 7'($urandom);
    end
    @(negedge clk);
    d8_in_valid = 0;
    #1;
    n_cmp++; if (d8_out_valid !== 1'b1 || d8_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_full: got valid %b ready %b want 1 0", d8_out_valid, d8_in_ready); end
    rst = 1'b1;
    #1;
    n_cmp++; if (d8_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b want 0", d8_out_valid); end
    n_cmp++; if (d8_cnt !== 4'h0) begin n_fail++; $display("FAIL rst_async_cnt: got %0d want 0", d8_cnt); end
    @(negedge clk);
    rst = 1'b0;
    d8_out_ready = 1;
    @(negedge clk);
    n_cmp++; if (d8_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_leak: got out_valid %b want 0", d8_out_valid); end
    // one set, then exactly two cycles to out_valid
    d8_in_mode = 1;
    make_set(8, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), 1'b1, lo, mid, hi, ex);
    d8_lo = lo[6:0]; d8_mid = mid[6:0]; d8_hi = hi[6:0];
    d8_in_valid = 1;
    @(negedge clk);
    d8_in_valid = 0;
    @(negedge clk);
    n_cmp++; if (d8_out_valid !== 1'b1 || d8_prod !== ex[14:0]) begin n_fail++; $display("FAIL rst_first: got valid %b prod %h want 1 %h", d8_out_valid, d8_prod, ex[14:0]); end
    // 15 more back-to-back products bring the 4-bit count from 0 around to 0
    for (int s = 0; s < 15 || recv < 15; s++) begin
      if (cyc >= 100) break;
      @(negedge clk);
      if (s < 15) begin
        d8_in_mode = 1'($urandom_range(0, 1));
        make_set(8, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), d8_in_mode, lo, mid, hi, ex);
        d8_lo = lo[6:0]; d8_mid = mid[6:0]; d8_hi = hi[6:0]; ex_cur = ex[14:0];
        d8_in_valid = 1;
      end else begin
        d8_in_valid = 0;
      end
      #1;
      if (d8_in_valid && d8_in_ready) q.push_back(ex_cur);
      if (d8_out_valid && (s > 0)) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL wrap_spurious: got product %h want none", d8_prod);
        end else begin
          got_exp = q.pop_front();
          if (d8_prod !== got_exp) begin n_fail++; $display("FAIL wrap_prod[%0d]: got %h want %h", recv, d8_prod, got_exp); end
        end
        recv++;
      end
      cyc++;
    end
    d8_in_valid = 0;
    n_cmp++; if (recv != 15) begin n_fail++; $display("FAIL wrap_recv: got %0d want 15", recv); end
    @(negedge clk);
    n_cmp++; if (d8_cnt !== 4'h0) begin n_fail++; $display("FAIL wrap_cnt: got %0d want 0", d8_cnt); end
  endtask

  initial begin
    test_reset();
    test_directed_n8();
    test_back_to_back_n64();
    test_backpressure_n8();
    test_reset_midop_n8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
